// File: rtl/weight_mem_sequencer_pkg.sv
// Shared types and defaults for the weight-memory control sequencer.
// Imported by the sequencer top and its word counter.
package weight_mem_sequencer_pkg;

  localparam int DEF_BIT_WIDTH   = 32;
  localparam int DEF_EXTRA_BITS  = 2;
  localparam int DEF_NUM_WEIGHTS = 4;
  localparam int DEF_MAX_ITER    = 1024;
  localparam int DEF_ITER_W      = 11;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INIT    = 4'd1,
    S_TRAIN   = 4'd2,
    S_EVAL    = 4'd3,
    S_UPDATE  = 4'd4,
    S_RESTORE = 4'd5,
    S_CHECK   = 4'd6,
    S_FIN     = 4'd7,
    S_DONE    = 4'd8
  } state_e;

  function automatic int word_w(input int bw, input int eb);
    return bw + eb;
  endfunction

endpackage

// File: rtl/weight_mem_sequencer_counter.sv
// Word counter for multi-word states: clear/load/enable,
// wraps modulo N and flags the last word.
module seq_word_counter
  import weight_mem_sequencer_pkg::*;
#(
  parameter int N  = DEF_NUM_WEIGHTS,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] ld_val,
  input  logic          en,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = ld_val;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/weight_mem_sequencer.sv
// Control FSM in front of the weight memories: initial load,
// per-iteration write/judge/commit-or-restore, best-set stream-out.
module weight_mem_sequencer
  import weight_mem_sequencer_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int EXTRA_BITS  = DEF_EXTRA_BITS,
  parameter int NUM_WEIGHTS = DEF_NUM_WEIGHTS,
  parameter int MAX_ITER    = DEF_MAX_ITER,
  parameter int ITER_W      = DEF_ITER_W,
  localparam int W = word_w(BIT_WIDTH, EXTRA_BITS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              train_valid,
  input  logic              err_valid,
  input  logic [W-1:0]      err_in,
  input  logic [W-1:0]      tol,
  output logic              local_initial_read_flag,
  output logic              local_write_training,
  output logic              local_write_en,
  output logic              old_weight_rd,
  output logic              Update_Weight,
  output logic              local_finish,
  output logic              busy,
  output logic              converged,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [W-1:0]      best_err
);

  localparam int CW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_e            state_q, state_d;
  logic [W-1:0]      tol_q, tol_d;
  logic [W-1:0]      best_q, best_d;
  logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
  logic              conv_q, conv_d;
  logic              ird_q, ird_d;
  logic              wtr_q, wtr_d;
  logic              owr_q, owr_d;
  logic              upd_q, upd_d;
  logic              fin_q, fin_d;
  logic              busy_q, busy_d;
  logic              wc_en, wc_clr, wc_tc;

  seq_word_counter #(
    .N  (NUM_WEIGHTS),
    .CW (CW)
  ) u_word_cnt (
    .clk    (CLK),
    .rst_n  (RESET),
    .clr    (wc_clr),
    .load   (1'b0),
    .ld_val ('0),
    .en     (wc_en),
    .tc     (wc_tc)
  );

  assign iter_inc = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tol_d   = tol_q;
    best_d  = best_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    wc_en   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_INIT;
          tol_d   = tol;
          best_d  = '1;
          iter_d  = '0;
          conv_d  = 1'b0;
        end
      end
      S_INIT: begin
        wc_en = 1'b1;
        if (wc_tc) state_d = S_TRAIN;
      end
      S_TRAIN: begin
        wc_en = train_valid;
        if (train_valid && wc_tc) state_d = S_EVAL;
      end
      // err_in is only valid for one cycle, so it is captured here
      S_EVAL: begin
        if (err_valid) begin
          iter_d = iter_inc;
          if (err_in < best_q) begin
            best_d  = err_in;
            state_d = S_UPDATE;
          end else begin
            state_d = S_RESTORE;
          end
        end
      end
      S_UPDATE: state_d = S_CHECK;
      S_RESTORE: begin
        wc_en = 1'b1;
        if (wc_tc) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (best_q <= tol_q) begin
          conv_d  = 1'b1;
          state_d = S_FIN;
        end else if (iter_q == ITER_MAX) begin
          state_d = S_FIN;
        end else begin
          state_d = S_TRAIN;
        end
      end
      S_FIN: begin
        wc_en = 1'b1;
        if (wc_tc) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    wc_clr = (state_d != state_q);
    ird_d  = (state_d == S_INIT);
    wtr_d  = (state_q == S_TRAIN) && train_valid;
    owr_d  = (state_d == S_RESTORE);
    upd_d  = (state_d == S_UPDATE);
    fin_d  = (state_d == S_FIN);
    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      tol_q   <= '0;
      best_q  <= '1;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      ird_q   <= 1'b0;
      wtr_q   <= 1'b0;
      owr_q   <= 1'b0;
      upd_q   <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tol_q   <= tol_d;
      best_q  <= best_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      ird_q   <= ird_d;
      wtr_q   <= wtr_d;
      owr_q   <= owr_d;
      upd_q   <= upd_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
    end
  end

  assign local_initial_read_flag = ird_q;
  assign local_write_training    = wtr_q;
  assign local_write_en          = wtr_q;
  assign old_weight_rd           = owr_q;
  assign Update_Weight           = upd_q;
  assign local_finish            = fin_q;
  assign busy                    = busy_q;
  assign converged               = conv_q;
  assign iter_cnt                = iter_q;
  assign best_err                = best_q;

endmodule

// File: tb/tb_weight_mem_sequencer.sv
// Scoreboard bench for weight_mem_sequencer (MAX_ITER=3).
// Per-cycle strobe expectations are queued with stimulus.
module tb_weight_mem_sequencer;

  localparam int W = 34;

  localparam logic [6:0] E_IDLE = 7'b0000000;
  localparam logic [6:0] E_BUSY = 7'b0000001;
  localparam logic [6:0] E_INIT = 7'b1000001;
  localparam logic [6:0] E_WR   = 7'b0110001;
  localparam logic [6:0] E_OWR  = 7'b0001001;
  localparam logic [6:0] E_UPD  = 7'b0000101;
  localparam logic [6:0] E_FIN  = 7'b0000011;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         start = 1'b0;
  logic         train_valid = 1'b0;
  logic         err_valid = 1'b0;
  logic [W-1:0] err_in = '0;
  logic [W-1:0] tol = '0;
  logic         ird, wtr, wen, owr, upd, fin, busy, converged;
  logic [10:0]  iter_cnt;
  logic [W-1:0] best_err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic         st;
    logic         tv;
    logic         ev;
    logic [W-1:0] err;
  } stim_t;

  stim_t      stim_q[$];
  logic [6:0] exp_q[$];
  logic [6:0] e;
  logic [W-1:0] all_ones;

  always #5 CLK = ~CLK;

  weight_mem_sequencer #(
    .BIT_WIDTH   (32),
    .EXTRA_BITS  (2),
    .NUM_WEIGHTS (4),
    .MAX_ITER    (3),
    .ITER_W      (11)
  ) dut (
    .CLK                     (CLK),
    .RESET                   (RESET),
    .start                   (start),
    .train_valid             (train_valid),
    .err_valid               (err_valid),
    .err_in                  (err_in),
    .tol                     (tol),
    .local_initial_read_flag (ird),
    .local_write_training    (wtr),
    .local_write_en          (wen),
    .old_weight_rd           (owr),
    .Update_Weight           (upd),
    .local_finish            (fin),
    .busy                    (busy),
    .converged               (converged),
    .iter_cnt                (iter_cnt),
    .best_err                (best_err)
  );

  function automatic logic [6:0] obs();
    return {ird, wtr, wen, owr, upd, fin, busy};
  endfunction

  task automatic push(input logic st, input logic tv, input logic ev,
                      input logic [W-1:0] err, input logic [6:0] ex);
    stim_q.push_back(stim_t'{st, tv, ev, err});
    exp_q.push_back(ex);
  endtask

  task automatic drive(input stim_t s);
    start = s.st;
    train_valid = s.tv;
    err_valid = s.ev;
    err_in = s.err;
    @(posedge CLK);
    #1;
    start = 1'b0;
    train_valid = 1'b0;
    err_valid = 1'b0;
    err_in = '0;
  endtask

  task automatic q_init();
    push(1'b1, 1'b0, 1'b0, '0, E_INIT);
    repeat (3) push(1'b0, 1'b0, 1'b0, '0, E_INIT);
  endtask

  task automatic q_words();
    push(1'b0, 1'b0, 1'b0, '0, E_BUSY);
    repeat (4) push(1'b0, 1'b1, 1'b0, '0, E_WR);
  endtask

  task automatic q_eval(input logic [W-1:0] err, input logic keep);
    push(1'b0, 1'b0, 1'b1, err, keep ? E_UPD : E_OWR);
    if (!keep) repeat (3) push(1'b0, 1'b0, 1'b0, '0, E_OWR);
    push(1'b0, 1'b0, 1'b0, '0, E_BUSY);
  endtask

  task automatic q_fin();
    repeat (4) push(1'b0, 1'b0, 1'b0, '0, E_FIN);
    repeat (2) push(1'b0, 1'b0, 1'b0, '0, E_IDLE);
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if (obs() !== E_IDLE) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want %b", obs(), E_IDLE);
    end
    n_chk++;
    if (iter_cnt !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_iter: got %0d want 0", iter_cnt);
    end
    n_chk++;
    if (best_err !== all_ones) begin
      n_fail++;
      $display("FAIL reset_best: got %h want %h", best_err, all_ones);
    end
    n_chk++;
    if (converged !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_conv: got %b want 0", converged);
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_start();
    tol = W'(50);
    q_init();
    push(1'b0, 1'b0, 1'b0, '0, E_BUSY);
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL start cyc%0d: got %b want %b", c, obs(), e);
      end
    end
  endtask

  task automatic test_train();
    push(1'b0, 1'b1, 1'b0, '0, E_WR);
    push(1'b0, 1'b1, 1'b0, '0, E_WR);
    push(1'b1, 1'b0, 1'b0, '0, E_BUSY);
    push(1'b0, 1'b1, 1'b0, '0, E_WR);
    push(1'b0, 1'b1, 1'b0, '0, E_WR);
    push(1'b0, 1'b1, 1'b0, '0, E_BUSY);
    push(1'b1, 1'b0, 1'b0, '0, E_BUSY);
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL train cyc%0d: got %b want %b", c, obs(), e);
      end
    end
  endtask

  task automatic test_update_restore();
    q_eval(W'(100), 1'b1);
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL update cyc%0d: got %b want %b", c, obs(), e);
      end
    end
    n_chk++;
    if (best_err !== W'(100) || iter_cnt !== 11'd1) begin
      n_fail++;
      $display("FAIL update_regs: got best=%0d iter=%0d want 100/1",
               best_err, iter_cnt);
    end
    q_words();
    q_eval(W'(100), 1'b0);
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL restore cyc%0d: got %b want %b", c, obs(), e);
      end
    end
    n_chk++;
    if (best_err !== W'(100) || iter_cnt !== 11'd2 || converged !== 1'b0) begin
      n_fail++;
      $display("FAIL restore_regs: got best=%0d iter=%0d conv=%b want 100/2/0",
               best_err, iter_cnt, converged);
    end
  endtask

  task automatic test_max_iter();
    q_words();
    q_eval(W'(200), 1'b0);
    q_fin();
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL max_iter cyc%0d: got %b want %b", c, obs(), e);
      end
    end
    n_chk++;
    if (converged !== 1'b0 || iter_cnt !== 11'd3 || best_err !== W'(100)) begin
      n_fail++;
      $display("FAIL max_iter_regs: got conv=%b iter=%0d best=%0d want 0/3/100",
               converged, iter_cnt, best_err);
    end
  endtask

  task automatic test_converge();
    tol = W'(50);
    q_init();
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL conv_init cyc%0d: got %b want %b", c, obs(), e);
      end
    end
    n_chk++;
    if (best_err !== all_ones || iter_cnt !== 11'd0 || converged !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_restart: got best=%h iter=%0d conv=%b want ones/0/0",
               best_err, iter_cnt, converged);
    end
    tol = '0;
    q_words();
    q_eval(W'(60), 1'b1);
    q_words();
    q_eval(W'(40), 1'b1);
    q_fin();
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL converge cyc%0d: got %b want %b", c, obs(), e);
      end
    end
    n_chk++;
    if (converged !== 1'b1 || iter_cnt !== 11'd2 || best_err !== W'(40)) begin
      n_fail++;
      $display("FAIL conv_regs: got conv=%b iter=%0d best=%0d want 1/2/40",
               converged, iter_cnt, best_err);
    end
  endtask

  task automatic test_both_limits();
    tol = W'(50);
    q_init();
    q_words();
    q_eval(W'(100), 1'b1);
    q_words();
    q_eval(W'(100), 1'b0);
    q_words();
    q_eval(W'(40), 1'b1);
    q_fin();
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL both cyc%0d: got %b want %b", c, obs(), e);
      end
    end
    n_chk++;
    if (converged !== 1'b1 || iter_cnt !== 11'd3) begin
      n_fail++;
      $display("FAIL both_regs: got conv=%b iter=%0d want 1/3",
               converged, iter_cnt);
    end
  endtask

  task automatic test_reset_mid();
    tol = W'(50);
    q_init();
    push(1'b0, 1'b0, 1'b0, '0, E_BUSY);
    push(1'b0, 1'b1, 1'b0, '0, E_WR);
    push(1'b0, 1'b1, 1'b0, '0, E_WR);
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL pre_reset cyc%0d: got %b want %b", c, obs(), e);
      end
    end
    train_valid = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    n_chk++;
    if (obs() !== E_IDLE || iter_cnt !== 11'd0 || best_err !== all_ones) begin
      n_fail++;
      $display("FAIL async_reset: got strobes=%b iter=%0d best=%h want 0/0/ones",
               obs(), iter_cnt, best_err);
    end
    train_valid = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    q_init();
    push(1'b0, 1'b0, 1'b0, '0, E_BUSY);
    push(1'b0, 1'b1, 1'b0, '0, E_WR);
    for (int c = 1; exp_q.size() != 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL restart cyc%0d: got %b want %b", c, obs(), e);
      end
    end
  endtask

  initial begin
    all_ones = '1;
    test_reset();
    test_start();
    test_train();
    test_update_restore();
    test_max_iter();
    test_converge();
    test_both_limits();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
